// File: rtl/shreg_seq_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | shreg_seq_ctrl_if : word ports and register-chain signals for the         |
// |                     shift-register sequencer.          Rev 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface shreg_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sr_d;
  logic             sr_en;
  logic [WIDTH-1:0] sr_q;
  logic             abort;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [CW-1:0]    bit_cnt;

  // Environment side: producer, consumer and the register chain.
  modport master (
    output in_data, in_valid, sr_q, abort, out_ready,
    input  in_ready, sr_d, sr_en, out_data, out_valid, busy, bit_cnt
  );

  // Sequencer side.
  modport slave (
    input  in_data, in_valid, sr_q, abort, out_ready,
    output in_ready, sr_d, sr_en, out_data, out_valid, busy, bit_cnt
  );
endinterface

`default_nettype wire

// File: rtl/shreg_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | shreg_seq_ctrl : serialises a word into a SIPO shift register, waits a    |
// |                  settle window and returns the captured taps. Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module shreg_seq_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter int SETTLE_CYC = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  shreg_seq_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]    set_cnt_q, set_cnt_d;
  logic             sr_en_q, sr_en_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] taps_cap;
  logic             sr_bit;

  // tx shifts toward the serial port, filling with zeros, so it is all-zero
  // outside SHIFT and its edge bit can drive sr_d straight from a flop.
  if (LSB_FIRST) begin : g_lsb
    assign tx_shift = tx_q >> 1;
    assign sr_bit   = tx_q[0];
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
      assign taps_cap[i] = bus.sr_q[WIDTH-1-i];
    end
  end else begin : g_msb
    assign tx_shift = tx_q << 1;
    assign sr_bit   = tx_q[WIDTH-1];
    assign taps_cap = bus.sr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_q       <= '0;
      bit_cnt_q  <= '0;
      set_cnt_q  <= '0;
      sr_en_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      bit_cnt_q  <= bit_cnt_d;
      set_cnt_q  <= set_cnt_d;
      sr_en_q    <= sr_en_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.in_valid) state_d = S_SHIFT;
      S_SHIFT:  if (bus.abort) state_d = S_IDLE;
                else if (bit_cnt_q == CNT_LAST) state_d = S_SETTLE;
      S_SETTLE: if (bus.abort) state_d = S_IDLE;
                else if (set_cnt_q == SET_LAST) state_d = S_HOLD;
      S_HOLD:   if (bus.out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d       = tx_q;
    bit_cnt_d  = bit_cnt_q;
    set_cnt_d  = set_cnt_q;
    sr_en_d    = 1'b0;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        set_cnt_d = '0;
        if (bus.in_valid) begin
          tx_d    = bus.in_data;
          sr_en_d = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bus.abort) begin
          tx_d      = '0;
          bit_cnt_d = '0;
        end else begin
          tx_d      = tx_shift;
          bit_cnt_d = bit_cnt_q + 1'b1;
          sr_en_d   = (bit_cnt_q != CNT_LAST);
        end
      end
      S_SETTLE: begin
        if (bus.abort) begin
          bit_cnt_d = '0;
          set_cnt_d = '0;
        end else if (set_cnt_q == SET_LAST) begin
          set_cnt_d  = '0;
          out_data_d = taps_cap;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) bit_cnt_d = '0;
      end
      default: begin
        tx_d      = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.sr_en     = sr_en_q;
  assign bus.sr_d      = sr_bit;
  assign bus.out_data  = out_data_q;
  assign bus.bit_cnt   = (bit_cnt_q > CNT_FULL) ? CNT_FULL : bit_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_shreg_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_shreg_seq_ctrl : two sequencers (LSB- and MSB-first) looped through    |
// |                     ideal shift registers; round-trip word model. Rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_shreg_seq_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] sra = '0;
  logic [W-1:0] srb = '0;
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  shreg_seq_ctrl_if #(.WIDTH(W)) ifa ();
  shreg_seq_ctrl_if #(.WIDTH(W)) ifb ();

  assign ifa.in_data   = in_data;
  assign ifa.in_valid  = in_valid;
  assign ifa.out_ready = out_ready;
  assign ifa.abort     = abort;
  assign ifa.sr_q      = sra;
  assign ifb.in_data   = in_data;
  assign ifb.in_valid  = in_valid;
  assign ifb.out_ready = out_ready;
  assign ifb.abort     = abort;
  assign ifb.sr_q      = srb;

  // Ideal register chains: D enters stage 0 and moves toward stage W-1.
  always @(posedge clk) begin
    if (ifa.sr_en) sra <= {sra[W-2:0], ifa.sr_d};
    if (ifb.sr_en) srb <= {srb[W-2:0], ifb.sr_d};
  end

  shreg_seq_ctrl #(.WIDTH(W), .LSB_FIRST(1'b1), .SETTLE_CYC(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  shreg_seq_ctrl #(.WIDTH(W), .LSB_FIRST(1'b0), .SETTLE_CYC(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy_a"}, 32'(ifa.in_ready), 1);
    chk({tag, "_rdy_b"}, 32'(ifb.in_ready), 1);
    chk({tag, "_ov"},    32'(ifa.out_valid | ifb.out_valid), 0);
    chk({tag, "_en"},    32'(ifa.sr_en | ifb.sr_en), 0);
    chk({tag, "_sd"},    32'(ifa.sr_d | ifb.sr_d), 0);
    chk({tag, "_busy"},  32'(ifa.busy | ifb.busy), 0);
    chk({tag, "_cnt_a"}, 32'(ifa.bit_cnt), 0);
    chk({tag, "_cnt_b"}, 32'(ifb.bit_cnt), 0);
  endtask

  // One full word: expected serial order and round-trip value come from w only.
  task automatic run_word(input logic [W-1:0] w, input int hold, input bit abort_acc);
    chk("acc_rdy", 32'(ifa.in_ready & ifb.in_ready), 1);
    in_data  = w;
    in_valid = 1'b1;
    abort    = abort_acc;
    step();
    in_valid = 1'b0;
    abort    = 1'b0;
    in_data  = W'($urandom);
    for (int k = 0; k < W; k++) begin
      chk("shift_en_a", 32'(ifa.sr_en), 1);
      chk("shift_en_b", 32'(ifb.sr_en), 1);
      chk("sd_lsb", 32'(ifa.sr_d), 32'(w[k]));
      chk("sd_msb", 32'(ifb.sr_d), 32'(w[W-1-k]));
      chk("shift_cnt", 32'(ifa.bit_cnt), k);
      chk("shift_rdy", 32'(ifa.in_ready | ifb.in_ready), 0);
      step();
    end
    for (int s = 0; s < 2; s++) begin
      chk("settle_en", 32'(ifa.sr_en | ifb.sr_en), 0);
      chk("settle_sd", 32'(ifa.sr_d | ifb.sr_d), 0);
      chk("settle_cnt", 32'(ifa.bit_cnt), W);
      chk("settle_ov", 32'(ifa.out_valid | ifb.out_valid), 0);
      step();
    end
    chk("lat_ov_a", 32'(ifa.out_valid), 1);
    chk("lat_ov_b", 32'(ifb.out_valid), 1);
    chk("data_a", 32'(ifa.out_data), 32'(w));
    chk("data_b", 32'(ifb.out_data), 32'(w));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'($urandom);
      abort     = 1'b1;
      step();
      chk("hold_ov", 32'(ifa.out_valid & ifb.out_valid), 1);
      chk("hold_data_a", 32'(ifa.out_data), 32'(w));
      chk("hold_data_b", 32'(ifb.out_data), 32'(w));
      chk("hold_rdy", 32'(ifa.in_ready | ifb.in_ready), 0);
      chk("hold_cnt", 32'(ifb.bit_cnt), W);
    end
    in_valid  = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_idle("done");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    // Reset asserted between edges: outputs must settle with no clock.
    #2 rst_n = 1'b0;
    #2 chk_idle("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_en", 32'(ifa.sr_en | ifb.sr_en), 0);
      chk("post_rst_rdy", 32'(ifa.in_ready), 1);
      step();
    end

    run_word(8'hA5, 0, 1'b0);
    run_word(8'h3C, 6, 1'b0);
    run_word(8'hC3, 0, 1'b0);

    // Abort mid-shift.
    in_data  = 8'hFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("abort_pre_cnt", 32'(ifa.bit_cnt), 4);
    chk("abort_pre_en", 32'(ifa.sr_en), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort_shift");
    seen = 0;
    repeat (12) begin
      step();
      if (ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0) seen++;
    end
    chk("abort_no_ov", 32'(seen), 0);
    run_word(8'h01, 0, 1'b0);

    // Abort during the settle window.
    in_data  = 8'h77;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    chk("settle_abort_pre", 32'(ifa.bit_cnt), W);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort_settle");
    step();
    chk("settle_abort_ov", 32'(ifa.out_valid | ifb.out_valid), 0);

    // Abort coincident with accept in IDLE has no effect.
    run_word(8'h96, 0, 1'b1);

    // Asynchronous reset mid-shift.
    in_data  = 8'hE7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("arst_pre_cnt", 32'(ifa.bit_cnt), 3);
    #2 rst_n = 1'b0;
    #1 chk_idle("arst");
    #3 rst_n = 1'b1;
    step();
    chk_idle("arst_rel");
    run_word(8'h5A, 1, 1'b0);

    run_word(8'h80, 0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      run_word(W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
